// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock edge monitor: state encoding and
// default parameter values.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } mon_state_e;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_TIMEOUT    = 1000;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_TOL        = 1;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for signals arriving from another clock domain
// or from board pins.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/clk_edge_monitor.sv
// Synchronizes a slow divided clock, emits rise/fall enable strobes, measures
// its rise-to-rise period and tracks lock/loss health.
module clk_edge_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TOL        = DEF_TOL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOL_V      = CNT_W'(TOL);
    localparam logic [MC_W-1:0]  LOCK_V     = MC_W'(LOCK_COUNT);

    logic             s2;
    logic             s3_q;
    logic             rise;
    logic             fall;
    logic             rise_q, fall_q;
    logic             locked_q, lost_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic [MC_W-1:0]  match_q, match_d;
    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] period_new;
    logic [CNT_W-1:0] diff;
    logic             is_match;
    logic             timeout;

    sync_2ff u_sync (
        .clk (clk),
        .rst (reset),
        .d_i (sig_in),
        .q_o (s2)
    );

    assign rise = s2 & ~s3_q;
    assign fall = ~s2 & s3_q;

    // The period includes the rise cycle itself, hence cnt+1, clamped at full scale.
    assign period_new = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    assign diff       = (period_new >= period_q) ? (period_new - period_q)
                                                 : (period_q - period_new);
    assign is_match   = valid_q && (diff <= TOL_V);
    assign timeout    = (cnt_q == TIMEOUT_M1) && !rise;

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        period_d = period_q;
        valid_d  = valid_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (rise) begin
            cnt_d = '0;
        end

        unique case (state_q)
            IDLE, LOST: begin
                // First rise only restarts the count; its period is not trustworthy.
                if (rise) begin
                    state_d = ACQ;
                    match_d = '0;
                end else if (timeout && state_q == IDLE) begin
                    state_d = LOST;
                    valid_d = 1'b0;
                end
            end
            ACQ: begin
                if (rise) begin
                    period_d = period_new;
                    valid_d  = 1'b1;
                    if (valid_q) begin
                        if (is_match) begin
                            match_d = match_q + MC_W'(1);
                            if (match_q + MC_W'(1) >= LOCK_V) begin
                                match_d = LOCK_V;
                                state_d = LOCKED;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end else if (timeout) begin
                    state_d = LOST;
                    valid_d = 1'b0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = period_new;
                    if (!is_match) begin
                        state_d = ACQ;
                        match_d = '0;
                    end
                end else if (timeout) begin
                    state_d = LOST;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags decode the next state so they move on the same edge as the strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= '0;
            state_q  <= IDLE;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            s3_q     <= s2;
            rise_q   <= rise;
            fall_q   <= fall;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            state_q  <= state_d;
            locked_q <= (state_d == LOCKED);
            lost_q   <= (state_d == LOST);
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign lost         = lost_q;

endmodule
